// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device transmitter. Sends one command byte to the
//             device as an open-drain frame. The frame is start(0), D0..D7
//             LSB first, odd parity, stop(released), then the device ACK.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk          in   system clock
//    rstn         in   asynchronous active-low reset
//    tx_data[7:0] in   command byte, sampled on accept
//    tx_valid     in   send request (accepted when tx_valid && tx_ready)
//    tx_ready     out  high only when idle and no completion pulse is pending
//    tx_done      out  1-cycle pulse: frame sent (and ACKed if checked)
//    tx_err       out  1-cycle pulse: timeout or missing ACK
//    busy         out  high from accept until return to idle
//    PS2Clk       in   raw PS/2 clock pin (2-FF sync + glitch filter)
//    PS2Data      in   raw PS/2 data pin (2-FF sync)
//    ps2_clk_oe   out  1 = pull PS2Clk low
//    ps2_data_oe  out  1 = pull PS2Data low
//
//  Build option
//    PS2_TX_ACK_CHECK_EN : when defined, a high PS2Data at edge 11 (no ACK)
//                          turns the completion into tx_err.
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = $clog2(FILTER_LEN + 1);

  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INHIBIT  = 3'd1,
    S_RELEASE  = 3'd2,
    S_SHIFT    = 3'd3,
    S_ACK      = 3'd4,
    S_WAITIDLE = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Pin synchronisers and PS2Clk glitch filter. Lines idle high.
  // --------------------------------------------------------------------------
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          clk_f_q, clk_f_prev_q;
  logic [FW-1:0] flt_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      clk_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
      flt_cnt_q    <= '0;
    end else begin
      clk_s1_q     <= PS2Clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= PS2Data;
      dat_s2_q     <= dat_s1_q;
      clk_f_prev_q <= clk_f_q;
      // A new level is accepted only after FILTER_LEN consecutive samples
      // disagree with the current filtered level; any agreeing sample restarts.
      if (clk_s2_q != clk_f_q) begin
        if (flt_cnt_q == FLT_LAST) begin
          clk_f_q   <= clk_s2_q;
          flt_cnt_q <= '0;
        end else begin
          flt_cnt_q <= flt_cnt_q + 1'b1;
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  logic fall;
  assign fall = clk_f_prev_q & ~clk_f_q;

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shreg_q, shreg_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef PS2_TX_ACK_CHECK_EN
  logic          ack_q, ack_d;
`endif

  logic to_active;
  logic [3:0] bit_cnt_inc;

  assign to_active   = (state_q == S_RELEASE) || (state_q == S_SHIFT) ||
                       (state_q == S_ACK)     || (state_q == S_WAITIDLE);
  assign bit_cnt_inc = (bit_cnt_q == 4'd11) ? 4'd11 : bit_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_q     <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_q     <= ack_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_d     = ack_q;
`endif
    // Device-clock watchdog: held at zero outside the wire phases so every
    // frame starts from a clean count; any falling edge restarts it.
    to_cnt_d  = (!to_active || fall) ? '0 : to_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_d   = {~^tx_data, tx_data};
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        // Filtered edges here are our own clock pull-down and are ignored.
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;                // stop bit: release the line
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~shreg_q[0];         // open drain: pull low for a 0
            shreg_d   = {1'b0, shreg_q[8:1]};
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_inc;
`ifdef PS2_TX_ACK_CHECK_EN
          ack_d     = dat_s2_q;
`endif
          state_d   = S_WAITIDLE;
        end
      end
      S_WAITIDLE: begin
        if (clk_s2_q && dat_s2_q) begin
`ifdef PS2_TX_ACK_CHECK_EN
          err_d  = ack_q;
          done_d = ~ack_q;
`else
          done_d = 1'b1;
`endif
          state_d = S_IDLE;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Timeout overrides everything else, so done and err stay exclusive.
    if (to_active && (to_cnt_q == TO_LAST)) begin
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
      state_d   = S_IDLE;
    end
  end

  // The completion pulse is issued while already in IDLE; ready waits until
  // the pulse has gone so that a new request cannot overlap it.
  assign tx_ready    = (state_q == S_IDLE) && !done_q && !err_q;
  assign busy        = ~tx_ready;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = (state_q == S_INHIBIT);
  // Start bit goes out during the final inhibit cycle, before the clock release.
  assign ps2_data_oe = data_oe_q | ((state_q == S_INHIBIT) && (inh_cnt_q == INH_LAST));

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Self-checking bench for ps2_host_tx with a PS/2 device model.
//             Stimulus pushes expected results; a monitor pops and compares
//             on every tx_done/tx_err pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int IC = 50;
  localparam int TO = 300;
  localparam int FL = 8;
  localparam int H  = 20;   // device half clock period in system cycles

`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;
  logic       clk_line, data_line;

  // Open-drain wired-AND of host and device drivers.
  assign clk_line  = dev_clk  & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(IC),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .PS2Clk     (clk_line),
    .PS2Data    (data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       is_err;
    logic       has_frame;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] obs_q[$];
  int checks   = 0;
  int failures = 0;
  int n_sends  = 0;
  int n_acc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) if (rstn && tx_valid && tx_ready) n_acc++;

  initial begin : inhibit_mon
    int len;
    logic last_doe;
    len = 0;
    last_doe = 1'b0;
    forever begin
      @(negedge clk);
      if (ps2_clk_oe) begin
        len++;
        last_doe = ps2_data_oe;
      end else if (len > 0) begin
        chk("inhibit_len", len, IC);
        chk("start_bit_in_last_inhibit", last_doe, 1);
        len = 0;
      end
    end
  end

  initial begin : scoreboard
    exp_t e;
    logic [10:0] f;
    forever begin
      @(negedge clk);
      if (tx_done || tx_err) begin
        chk("done_err_exclusive", tx_done & tx_err, 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=done%0b/err%0b required=none", tx_done, tx_err);
        end else begin
          e = exp_q.pop_front();
          chk("result_is_err", tx_err, e.is_err);
          if (e.has_frame) begin
            if (obs_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL frame_missing actual=none required=%0h", {1'b1, e.par, e.data, 1'b0});
            end else begin
              f = obs_q.pop_front();
              chk("frame_on_wire", f, {1'b1, e.par, e.data, 1'b0});
            end
          end
        end
        @(negedge clk);
        chk("pulse_one_cycle", {tx_done, tx_err}, 0);
        chk("ready_after_pulse", tx_ready, 1);
        chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
      end
    end
  end

  // ---------------- device model ----------------
  task automatic device(input int n_edges, input bit ack, input bit glitch);
    int t;
    logic [10:0] frame;
    frame = '0;
    t = 0;
    while (!(clk_line && !data_line) && t < IC + 100) begin
      @(negedge clk);
      t++;
    end
    chk("host_release_seen", clk_line && !data_line, 1);
    repeat (H) @(negedge clk);
    for (int k = 0; k < n_edges; k++) begin
      frame[k] = data_line;   // bit driven by host, sampled before edge k+1
      if (k == 10) begin
        obs_q.push_back(frame);
        if (ack) dev_data = 1'b0;
      end
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      if (glitch) begin
        repeat (H / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H / 2 - 2) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic start_tx(input logic [7:0] d, input bit hold);
    int t;
    tx_data  = d;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_for_accept", tx_ready, 1);
    n_sends++;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!tx_ready && t < TO + 200) begin
      @(negedge clk);
      t++;
    end
    chk("returned_idle", tx_ready, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par, input bit ack,
                           input bit glitch, input bit hold);
    int t;
    exp_q.push_back('{d, par, (ack ? 1'b0 : ACK_CHK), 1'b1});
    start_tx(d, hold);
    device(11, ack, glitch);
    if (hold) begin
      t = 0;
      while (!(tx_done || tx_err) && t < TO + 200) begin
        @(negedge clk);
        t++;
      end
      tx_valid = 1'b0;
    end
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    int cyc;
    rstn     = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED: six ones -> parity 1; device ACKs
    run_frame(8'hED, 1'b1, 1'b1, 1'b0, 1'b0);
    // 0x07: three ones -> parity 0
    run_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);

    // Device never clocks -> timeout error
    exp_q.push_back('{8'h55, 1'b0, 1'b1, 1'b0});
    start_tx(8'h55, 1'b0);
    cyc = 0;
    while (!tx_err && cyc < IC + TO + 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_err_seen", tx_err, 1);
    chk("timeout_latency_window", (cyc >= IC + TO) && (cyc <= IC + TO + 10), 1);
    wait_idle();

    // 0x3C: four ones -> parity 1; device leaves data high at edge 11
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after edge 4 of 0xA5 (D3=0 -> data pulled low at that point)
    start_tx(8'hA5, 1'b0);
    device(4, 1'b0, 1'b0);
    chk("mid_frame_busy", busy, 1);
    chk("mid_frame_data_oe", ps2_data_oe, 1);
    rstn = 1'b0;
    #1;
    chk("async_rst_clk_oe", ps2_clk_oe, 0);
    chk("async_rst_data_oe", ps2_data_oe, 0);
    chk("async_rst_ready", tx_ready, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    // 0xFF: eight ones -> parity 1
    run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // 0x00 -> parity 1; tx_valid held across the frame, glitches on PS2Clk
    run_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("one_accept_per_send", n_acc, n_sends);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("frames_drained", obs_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
